// File: rtl/distributor_pkg.sv
// Shared constants and the round-robin lane search used by the stream distributor.
package distributor_pkg;

  // Upper bound on lane count supported by the lane search helper.
  localparam int MAX_LANES = 64;

  function automatic int lane_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // First lane with space at or after ptr, wrapping to the lowest lane below ptr.
  function automatic logic rr_first_free(
    input  logic [MAX_LANES-1:0] space,
    input  int                   n,
    input  int                   ptr,
    output int                   idx
  );
    logic found_hi;
    logic found_lo;
    int   idx_hi;
    int   idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = 0;
    idx_lo   = 0;
    for (int l = 0; l < MAX_LANES; l++) begin
      if (l < n && space[l]) begin
        if (l >= ptr && !found_hi) begin
          found_hi = 1'b1;
          idx_hi   = l;
        end
        if (l < ptr && !found_lo) begin
          found_lo = 1'b1;
          idx_lo   = l;
        end
      end
    end
    idx = found_hi ? idx_hi : idx_lo;
    return found_hi | found_lo;
  endfunction

endpackage

// File: rtl/distributor_lane_fifo.sv
// Per-lane FIFO with a registered head: rd_data is a flop that keeps its last
// value while the lane is empty, and a written item shows up one cycle later.
module distributor_lane_fifo
  import distributor_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              full,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              push;
  logic              pop;

  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign rd_data  = data_q;
  assign push     = wr_en & ~full;
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Head register tracks the next item, or holds the last one when draining empty.
    data_d = (count_d != '0) ? mem_d[rd_ptr_d] : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/distributor_rr.sv
// 1-to-N stream distributor: each accepted item goes to the next lane with free
// space in round-robin order; each lane buffers independently.
module distributor_rr
  import distributor_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int N      = 2,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = lane_idx_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid [N-1:0],
  output logic [DWIDTH-1:0] out_data  [N-1:0],
  input  logic              out_ready [N-1:0],
  output logic [PTR_W-1:0]  out_lane
);

  logic [N-1:0]     space;
  logic [N-1:0]     full;
  logic [N-1:0]     wr_en;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] target;
  logic             found;
  logic             accept;
  int               sel_idx;

  always_comb begin
    sel_idx = 0;
    found   = rr_first_free(MAX_LANES'(space), N, int'(rr_ptr_q), sel_idx);
    target  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == i) begin
        target = PTR_W'(i);
      end
    end
  end

  assign in_ready = rst_n & found;
  assign accept   = in_valid & in_ready;
  assign out_lane = target;

  // Explicit wrap so non-power-of-two lane counts work.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (target == PTR_W'(N - 1)) ? '0 : target + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign wr_en[gi] = accept && (target == PTR_W'(gi));
    assign space[gi] = ~full[gi];

    distributor_lane_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[gi]),
      .wr_data  (in_data),
      .full     (full[gi]),
      .rd_valid (out_valid[gi]),
      .rd_data  (out_data[gi]),
      .rd_ready (out_ready[gi])
    );
  end

endmodule

// File: tb/tb_distributor_rr.sv
// Randomized and directed bench for distributor_rr against a queue-based lane model.
module tb_distributor_rr;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid [1:0];
  logic [DW-1:0] out_data  [1:0];
  logic          out_ready [1:0];
  logic [0:0]    out_lane;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per lane, pointer, and last-shown head value.
  logic [DW-1:0] mq [2][$];
  logic [DW-1:0] shown [2];
  int            rr;

  always #5 clk = ~clk;

  distributor_rr #(.DWIDTH(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_lane  (out_lane)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      shown[i] = '0;
    end
    rr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(out_valid[i]), 32'd0);
      check($sformatf("%s_data%0d", tag, i), 32'(out_data[i]), 32'd0);
    end
  endtask

  // One clock cycle: drive, check against model, then advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r0, input logic r1);
    bit found;
    int tgt;
    bit acc;
    logic rdy [2];
    @(negedge clk);
    in_valid     = v;
    in_data      = d;
    out_ready[0] = r0;
    out_ready[1] = r1;
    rdy[0] = r0;
    rdy[1] = r1;
    #1;
    found = 1'b0;
    tgt   = 0;
    for (int k = 0; k < N; k++) begin
      int l;
      l = (rr + k) % N;
      if (!found && mq[l].size() < DEPTH) begin
        found = 1'b1;
        tgt   = l;
      end
    end
    check("in_ready", 32'(in_ready), 32'(found));
    for (int i = 0; i < N; i++) begin
      check($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
      check($sformatf("out_data%0d", i), 32'(out_data[i]), 32'(shown[i]));
    end
    acc = v && found;
    if (acc) begin
      check("out_lane", 32'(out_lane), 32'(tgt));
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0 && rdy[i]) begin
        void'(mq[i].pop_front());
      end
    end
    if (acc) begin
      mq[tgt].push_back(d);
      rr = (tgt + 1) % N;
      $display("push 0x%02h -> lane %0d", d, tgt);
    end
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        shown[i] = mq[i][0];
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with both consumers ready
    step(1'b1, 8'h11, 1'b1, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    drain();

    // Lane 1 stalled: it fills, remaining items go to lane 0
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'hA0 + 8'(k), 1'b1, 1'b0);
    end
    drain();

    // All lanes full, then one pop on lane 0 (no read-through)
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0);
    end
    step(1'b1, 8'hB4, 1'b1, 1'b0);
    step(1'b1, 8'hB4, 1'b0, 1'b0);
    check("lane0_count_after_refill", 32'(mq[0].size()), 32'd2);
    drain();

    // Pointer holds across idle cycles after an accept to lane 1
    while (rr != 1) begin
      step(1'b1, 8'hC0, 1'b1, 1'b1);
    end
    step(1'b1, 8'hC1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end
    step(1'b1, 8'hC2, 1'b1, 1'b1);
    drain();

    // Asynchronous reset with both lanes holding data
    step(1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hE0, 1'b1, 1'b1);
    drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/distributor_rr.md
Name: distributor_rr

Overview:
- 1-to-N stream distributor; the fan-out counterpart of the N-to-1 fixed-priority arbiter.
- Accepts one valid/ready input stream and spreads items across N output lanes using rotating (round-robin) priority among lanes with free space.
- Each lane has a small FIFO, so a stalled consumer does not block the others.
- Sits between a single producer (e.g. instruction/character fetch) and N parallel engines.

Parameters:
- DWIDTH, 8, data width in bits
- N, 2, number of output lanes; N >= 2
- DEPTH, 2, entries per lane FIFO; power of two, >= 2
- PTR_W, $clog2(N), width of the round-robin pointer and of the lane index (derived, not overridden)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has an item
- in_data  input  DWIDTH  producer item
- in_ready  output  1  item accepted this cycle when in_valid & in_ready
- out_valid  output  1 x [N-1:0] unpacked  lane i head is valid
- out_data  output  DWIDTH x [N-1:0] unpacked  lane i head data
- out_ready  input  1 x [N-1:0] unpacked  lane i consumer takes head when out_valid[i] & out_ready[i]
- out_lane  output  PTR_W  index of the lane written this cycle; meaningful only when in_valid & in_ready (debug/trace)

Behaviour:
- Reset (rst_n low, asynchronous):
  - all lane FIFOs empty; out_valid[i]=0; out_data[i]=0
  - rr_ptr=0; in_ready=0 while reset is asserted
- Lane space: space[i] = (count[i] < DEPTH), using the registered count.
  - No read-through: a lane that is full at cycle start is not writable that cycle, even if it is popped in the same cycle.
- Target selection (combinational):
  - Scan lanes rr_ptr, rr_ptr+1, ... mod N; target is the first lane with space[i]=1.
  - in_ready = OR of space[i], forced to 0 during reset.
  - out_lane = target.
- Accept (in_valid & in_ready):
  - in_data is written to the tail of the target lane.
  - rr_ptr <= (target+1) mod N.
  - Without an accept, rr_ptr holds.
  - Wrap: target=N-1 sets rr_ptr to 0.
- Latency: an accepted item appears at out_valid/out_data of its lane on the next cycle (1 cycle). No combinational path from in_valid/in_data to any lane output.
- Lane pop (out_valid[i] & out_ready[i]): head advances; count decrements.
- Push and pop on the same lane in one cycle: count unchanged; head advances; the new item goes to the tail.
- Push into an empty lane while its consumer is ready: the item is not visible until the next cycle.
- out_data[i] holds its previous value when out_valid[i]=0 (no X). After reset it is 0.
- Ordering: per-lane FIFO order is preserved. No global ordering guarantee across lanes.
- All lanes full: in_ready=0 and rr_ptr holds. A pop on any lane raises in_ready on the next cycle.
- in_valid=0: no state change other than pops. in_ready may be 1 regardless of in_valid.
- Reset mid-operation: contents are discarded immediately; outputs take their reset values asynchronously.
- Pointer arithmetic:
  - Lane FIFO rd/wr pointers are log2(DEPTH) bits with natural wrap.
  - count is log2(DEPTH)+1 bits.
  - rr_ptr wrap is an explicit compare against N-1, so N need not be a power of two.

Decomposition:
- Package distributor_pkg:
  - function rr_first_free(space vector, rr_ptr) returning lane index and a found flag
  - localparam helpers for PTR_W and count width
- Sub-module distributor_lane_fifo (DWIDTH, DEPTH):
  - ports clk, rst_n, wr_en, wr_data, full, rd_valid, rd_data, rd_ready
  - instantiated N times in a generate loop
- Top-level holds the rr_ptr register, the target select and the in_ready OR.

Test Plan:
- Config for all scenarios: N=2, DWIDTH=8, DEPTH=2.
- Round-robin, both consumers ready:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Required: lane0 outputs 0x11 then 0x33; lane1 outputs 0x22 then 0x44; each item appears 1 cycle after accept; in_ready stays 1.
- Skip a full lane:
  - Stimulus: out_ready[1]=0; push 0xA0..0xA5.
  - Required: lane1 fills with 0xA1, 0xA3; later items 0xA4, 0xA5 go to lane0; out_lane=0 for those accepts.
- All full:
  - Stimulus: both out_ready=0; push 5 items.
  - Required: 4 accepted, in_ready=0 after the 4th.
  - Then: assert out_ready[0] for 1 cycle; in_ready=1 the next cycle; the 5th item lands in lane0.
- Simultaneous push and pop on a full lane:
  - Stimulus: lane0 full, lane1 full, out_ready[0]=1 in cycle t.
  - Required: no accept in cycle t (no read-through); accept in t+1 into lane0; lane0 count ends at 2.
- Wrap and pointer hold:
  - Stimulus: accept to lane1, then idle 3 cycles, then push.
  - Required: rr_ptr stays 0 during idle; next item goes to lane0.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clock edges with data in both lanes.
  - Required: out_valid=0, out_data=0, in_ready=0 immediately; after release, the first push goes to lane0.
